// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate/data extender with valid/ready on both sides.
// The extension mode is applied as data enters stage 0; later stages only carry
// the result. DEPTH register stages sit between in_* and out_*.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [2:0]       occupancy
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             rdy_acc;
  logic [DEPTH-1:0] rdy;

  logic [DEPTH-1:0] v_q, v_d, up_v;
  logic [DEPTH-1:0] err_q, err_d, up_err;
  logic [OUT_W-1:0] data_q  [DEPTH];
  logic [OUT_W-1:0] data_d  [DEPTH];
  logic [OUT_W-1:0] up_data [DEPTH];

  // Extension of the incoming field according to in_op
  always_comb begin
    sext     = {{E{in_data[IN_W-1]}}, in_data};
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_op)
      3'b000:  ext_data = {{E{1'b0}}, in_data};
      3'b001:  ext_data = sext;
      3'b010:  ext_data = {in_data, {E{1'b0}}};
      3'b011:  ext_data = sext << 2;
      3'b100:  ext_data = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
      3'b101:  ext_data = {{(OUT_W-8){1'b0}}, in_data[7:0]};
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  // Ready chain: stage k is ready if it or any stage downstream has a hole,
  // or the consumer accepts. Built as a running OR from the output end so the
  // vector never reads itself.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy_acc            = rdy_acc | ~v_q[DEPTH-1-i];
      rdy[DEPTH-1-i]     = rdy_acc;
    end
  end

  // Next state per stage: a ready stage takes whatever sits upstream of it
  always_comb begin
    up_v       = '0;
    up_err     = '0;
    up_data    = '{default: '0};
    up_v[0]    = in_valid;
    up_err[0]  = ext_err;
    up_data[0] = ext_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      up_v[k]    = v_q[k-1];
      up_err[k]  = err_q[k-1];
      up_data[k] = data_q[k-1];
    end
    v_d    = v_q;
    err_d  = err_q;
    data_d = data_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = up_v[k];
        if (up_v[k]) begin
          err_d[k]  = up_err[k];
          data_d[k] = up_data[k];
        end
      end
    end
  end

  // Number of occupied stages
  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + 3'(v_q[k]);
    end
  end

  // Stage registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      err_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Directed and randomised checks of ext_pipe (DEPTH 2 main instance, plus
// DEPTH 1 and DEPTH 4 instances for latency and back-pressure).
module tb_ext_pipe;

  logic clk;
  logic reset;

  // main instance (DEPTH = 2)
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_data;
  logic [2:0]  in_op, occupancy;
  logic [31:0] out_data;

  // DEPTH = 1 instance
  logic        s1_iv, s1_ir, s1_ov, s1_or, s1_err;
  logic [15:0] s1_d;
  logic [2:0]  s1_op, s1_occ;
  logic [31:0] s1_od;

  // DEPTH = 4 instance
  logic        s4_iv, s4_ir, s4_ov, s4_or, s4_err;
  logic [15:0] s4_d;
  logic [2:0]  s4_op, s4_occ;
  logic [31:0] s4_od;

  ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .occupancy(occupancy));

  ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(s1_iv), .in_ready(s1_ir),
    .in_data(s1_d), .in_op(s1_op), .out_valid(s1_ov), .out_ready(s1_or),
    .out_data(s1_od), .out_err(s1_err), .occupancy(s1_occ));

  ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(s4_iv), .in_ready(s4_ir),
    .in_data(s4_d), .in_op(s4_op), .out_valid(s4_ov), .out_ready(s4_or),
    .out_data(s4_od), .out_err(s4_err), .occupancy(s4_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_emit = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  op;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
    bit          lat;
  } exp_t;

  vec_t  tbl [16];
  exp_t  sb [$];
  logic [31:0] cur_exp;
  logic        cur_err;
  bit          lat_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [15:0] d, input logic [2:0] op);
    logic [31:0] s;
    s = {{16{d[15]}}, d};
    case (op)
      3'd0:    return {1'b0, 16'h0000, d};
      3'd1:    return {1'b0, s};
      3'd2:    return {1'b0, d, 16'h0000};
      3'd3:    return {1'b0, s[29:0], 2'b00};
      3'd4:    return {1'b0, {24{d[7]}}, d[7:0]};
      3'd5:    return {1'b0, 24'h000000, d[7:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Scoreboard: record accepts, compare emits (sampled on the falling edge)
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_emit: got data=%h err=%b expected no item", out_data, out_err);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_err", 64'(out_err), 64'(e.e));
          if (e.lat) chk("latency", 64'(cyc - e.c), 64'd2);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cur_err, cyc, lat_mode});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [2:0] op,
                      input logic [31:0] e, input logic er);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    cur_exp  = e;
    cur_err  = er;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] d, input logic [2:0] op);
    logic [32:0] r;
    r = model(d, op);
    send(d, op, r[31:0], r[32]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a4, e0;
    logic [31:0] hold;
    bit rnd_done;

    tbl[0]  = '{16'h8001, 3'd0, 32'h0000_8001, 1'b0};
    tbl[1]  = '{16'h8001, 3'd1, 32'hFFFF_8001, 1'b0};
    tbl[2]  = '{16'h8001, 3'd2, 32'h8001_0000, 1'b0};
    tbl[3]  = '{16'h8001, 3'd3, 32'hFFFE_0004, 1'b0};
    tbl[4]  = '{16'h8001, 3'd4, 32'h0000_0001, 1'b0};
    tbl[5]  = '{16'h8001, 3'd5, 32'h0000_0001, 1'b0};
    tbl[6]  = '{16'h8001, 3'd6, 32'h0000_0000, 1'b1};
    tbl[7]  = '{16'h8001, 3'd7, 32'h0000_0000, 1'b1};
    tbl[8]  = '{16'h7FFF, 3'd1, 32'h0000_7FFF, 1'b0};
    tbl[9]  = '{16'h7FFF, 3'd3, 32'h0001_FFFC, 1'b0};
    tbl[10] = '{16'h1280, 3'd4, 32'hFFFF_FF80, 1'b0};
    tbl[11] = '{16'h1280, 3'd5, 32'h0000_0080, 1'b0};
    tbl[12] = '{16'h1234, 3'd2, 32'h1234_0000, 1'b0};
    tbl[13] = '{16'hFFFF, 3'd3, 32'hFFFF_FFFC, 1'b0};
    tbl[14] = '{16'hFFFF, 3'd0, 32'h0000_FFFF, 1'b0};
    tbl[15] = '{16'h00FF, 3'd4, 32'hFFFF_FFFF, 1'b0};

    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
    s1_iv = 1'b0; s1_d = '0; s1_op = '0; s1_or = 1'b0;
    s4_iv = 1'b0; s4_d = '0; s4_op = '0; s4_or = 1'b0;
    cur_exp = '0; cur_err = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_occ_d4", 64'(s4_occ), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // modes, back-to-back with latency check
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    for (int i = 0; i < 16; i++) send(tbl[i].d, tbl[i].op, tbl[i].exp, tbl[i].err);
    wait_drain();
    lat_mode = 1'b0;

    // back-pressure: 5 items with consumer stalled
    out_ready = 1'b0;
    e0 = n_emit;
    send_m(16'h0101, 3'd0);
    send_m(16'h0102, 3'd0);
    @(negedge clk);
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_data", 64'(out_data), 64'h0000_0101);
    hold = out_data;
    @(posedge clk);
    #1;
    fork
      begin
        send_m(16'h0103, 3'd0);
        send_m(16'h0104, 3'd0);
        send_m(16'h0105, 3'd0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_stable_data", 64'(out_data), 64'(hold));
          chk("bp_stall_ready", 64'(in_ready), 64'd0);
          chk("bp_stall_occ", 64'(occupancy), 64'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_emit_count", 64'(n_emit - e0), 64'd5);

    // full pipe streaming
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 12; i++) send_m(16'hA000 + 16'(i), 3'(i % 6));
      begin
        repeat (2) @(negedge clk);
        repeat (10) begin
          @(negedge clk);
          chk("stream_occ", 64'(occupancy), 64'd2);
          chk("stream_in_ready", 64'(in_ready), 64'd1);
          chk("stream_out_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    wait_drain();

    // reset mid-stream: in-flight items must never appear
    out_ready = 1'b0;
    send_m(16'h5555, 3'd1);
    send_m(16'h6666, 3'd1);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    in_op    = 3'd0;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // DEPTH 1 and DEPTH 4 latency
    s1_or = 1'b1; s4_or = 1'b1;
    s1_iv = 1'b1; s4_iv = 1'b1;
    s1_d = 16'h7FFF; s4_d = 16'h7FFF;
    s1_op = 3'd1; s4_op = 3'd1;
    @(negedge clk);
    chk("d1_in_ready", 64'(s1_ir), 64'd1);
    chk("d4_in_ready", 64'(s4_ir), 64'd1);
    @(posedge clk);
    #1;
    s1_iv = 1'b0; s4_iv = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("d1_out_valid", 64'(s1_ov), 64'd1);
        chk("d1_out_data", 64'(s1_od), 64'h0000_7FFF);
        chk("d1_out_err", 64'(s1_err), 64'd0);
      end
      chk("d4_out_valid", 64'(s4_ov), (i == 4) ? 64'd1 : 64'd0);
      if (i == 4) chk("d4_out_data", 64'(s4_od), 64'h0000_7FFF);
    end
    @(posedge clk);
    #1;

    // DEPTH 1 and DEPTH 4 back-pressure
    s1_or = 1'b0; s4_or = 1'b0;
    s1_iv = 1'b1; s4_iv = 1'b1;
    a1 = 0; a4 = 0;
    repeat (6) begin
      @(negedge clk);
      if (s1_ir) a1++;
      if (s4_ir) a4++;
      @(posedge clk);
      #1;
    end
    s1_iv = 1'b0; s4_iv = 1'b0;
    @(negedge clk);
    chk("d1_bp_accepts", 64'(a1), 64'd1);
    chk("d4_bp_accepts", 64'(a4), 64'd4);
    chk("d1_bp_occ", 64'(s1_occ), 64'd1);
    chk("d4_bp_occ", 64'(s4_occ), 64'd4);
    chk("d4_bp_in_ready", 64'(s4_ir), 64'd0);
    chk("d4_bp_data", 64'(s4_od), 64'h0000_7FFF);
    @(posedge clk);
    #1;
    s1_or = 1'b1; s4_or = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // random valid/ready traffic against the model
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_m(16'($urandom), 3'($urandom_range(0, 7)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
